// File: rtl/pe_sequencer.sv
// Static-schedule controller for the PE's 3-operand ALU: fetches one instruction per cycle,
// reads its three operands, presents them to the ALU and writes the result back, with no stalls.
module pe_sequencer #(
  parameter int DWIDTH    = 32,
  parameter int DM_AWIDTH = 8,
  parameter int IM_AWIDTH = 8,
  parameter int ALU_LAT   = 4,
  parameter int OPC_SKEW  = 3,
  parameter int IWIDTH    = 4 + 4*DM_AWIDTH + 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [IM_AWIDTH:0]   Inst_Count,
  output logic                 Busy,
  output logic                 Done,
  output logic [IM_AWIDTH-1:0] Inst_Addr,
  input  logic [IWIDTH-1:0]    Inst_Data,
  output logic [DM_AWIDTH-1:0] Dm_Rd_Addr0,
  output logic [DM_AWIDTH-1:0] Dm_Rd_Addr1,
  output logic [DM_AWIDTH-1:0] Dm_Rd_Addr2,
  input  logic [DWIDTH-1:0]    Dm_Rd_Data0,
  input  logic [DWIDTH-1:0]    Dm_Rd_Data1,
  input  logic [DWIDTH-1:0]    Dm_Rd_Data2,
  output logic [DWIDTH-1:0]    ALU_In0,
  output logic [DWIDTH-1:0]    ALU_In1,
  output logic [DWIDTH-1:0]    ALU_In2,
  output logic [3:0]           Opcode,
  input  logic [DWIDTH-1:0]    ALU_Out,
  output logic                 Dm_Wr_En,
  output logic [DM_AWIDTH-1:0] Dm_Wr_Addr,
  output logic [DWIDTH-1:0]    Dm_Wr_Data
);

  // Stage k of the delay line holds an instruction two cycles after its fetch address plus k;
  // the last stage feeds the write-back register, so its length is set by the ALU latency.
  localparam int DEPTH = ALU_LAT + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [IM_AWIDTH:0]   CNT_ONE = {{IM_AWIDTH{1'b0}}, 1'b1};
  localparam logic [IM_AWIDTH-1:0] PC_ONE  = {{(IM_AWIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                 state_q, state_d;
  logic [IM_AWIDTH-1:0]       pc_q, pc_d;
  logic [IM_AWIDTH:0]         count_q, count_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       fetch_v_q, fetch_v_d;
  logic [DEPTH-1:0]           pv_q, pv_d;
  logic [DEPTH-1:0][3:0]      pop_q, pop_d;
  logic [DEPTH-1:0][DM_AWIDTH-1:0] pdst_q, pdst_d;
  logic [DEPTH-1:0]           pwr_q, pwr_d;
  logic [DWIDTH-1:0]          alu_in0_q, alu_in0_d;
  logic [DWIDTH-1:0]          alu_in1_q, alu_in1_d;
  logic [DWIDTH-1:0]          alu_in2_q, alu_in2_d;
  logic [3:0]                 opcode_q, opcode_d;
  logic                       wr_en_q, wr_en_d;
  logic [DM_AWIDTH-1:0]       wr_addr_q, wr_addr_d;

  logic [3:0]                 inst_op_s;
  logic [DM_AWIDTH-1:0]       inst_dst_s;
  logic                       inst_wr_s;

  assign inst_op_s   = Inst_Data[IWIDTH-1 -: 4];
  assign Dm_Rd_Addr0 = Inst_Data[IWIDTH-5 -: DM_AWIDTH];
  assign Dm_Rd_Addr1 = Inst_Data[IWIDTH-5-DM_AWIDTH -: DM_AWIDTH];
  assign Dm_Rd_Addr2 = Inst_Data[IWIDTH-5-2*DM_AWIDTH -: DM_AWIDTH];
  assign inst_dst_s  = Inst_Data[DM_AWIDTH:1];
  assign inst_wr_s   = Inst_Data[0];

  // Sequencing FSM: program counter, run length capture, Busy and Done.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Inst_Count == {(IM_AWIDTH+1){1'b0}}) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            pc_d    = {IM_AWIDTH{1'b0}};
            count_d = Inst_Count;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if ({1'b0, pc_q} == (count_q - CNT_ONE)) begin
          state_d = DRAIN;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      DRAIN: begin
        // Done only once the final write has left the delay line.
        if (!fetch_v_q && (pv_q == {DEPTH{1'b0}})) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Operand capture, opcode/dst/wr delay lines and the write-back strobe.
  always_comb begin
    fetch_v_d = (state_q == RUN);
    pv_d      = {pv_q[DEPTH-2:0], fetch_v_q};
    pop_d     = {pop_q[DEPTH-2:0], inst_op_s};
    pdst_d    = {pdst_q[DEPTH-2:0], inst_dst_s};
    pwr_d     = {pwr_q[DEPTH-2:0], inst_wr_s};
    if (pv_q[0]) begin
      alu_in0_d = Dm_Rd_Data0;
      alu_in1_d = Dm_Rd_Data1;
      alu_in2_d = Dm_Rd_Data2;
    end else begin
      alu_in0_d = alu_in0_q;
      alu_in1_d = alu_in1_q;
      alu_in2_d = alu_in2_q;
    end
    if (pv_q[OPC_SKEW]) begin
      opcode_d = pop_q[OPC_SKEW];
    end else begin
      opcode_d = 4'b0000;
    end
    if (pv_q[ALU_LAT]) begin
      wr_en_d   = pwr_q[ALU_LAT] && (pop_q[ALU_LAT] != 4'b0000);
      wr_addr_d = pdst_q[ALU_LAT];
    end else begin
      wr_en_d   = 1'b0;
      wr_addr_d = {DM_AWIDTH{1'b0}};
    end
  end

  // All state; reset discards in-flight instructions so nothing is written back.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= {IM_AWIDTH{1'b0}};
      count_q   <= {(IM_AWIDTH+1){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fetch_v_q <= 1'b0;
      pv_q      <= {DEPTH{1'b0}};
      pop_q     <= '0;
      pdst_q    <= '0;
      pwr_q     <= {DEPTH{1'b0}};
      alu_in0_q <= {DWIDTH{1'b0}};
      alu_in1_q <= {DWIDTH{1'b0}};
      alu_in2_q <= {DWIDTH{1'b0}};
      opcode_q  <= 4'b0000;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {DM_AWIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fetch_v_q <= fetch_v_d;
      pv_q      <= pv_d;
      pop_q     <= pop_d;
      pdst_q    <= pdst_d;
      pwr_q     <= pwr_d;
      alu_in0_q <= alu_in0_d;
      alu_in1_q <= alu_in1_d;
      alu_in2_q <= alu_in2_d;
      opcode_q  <= opcode_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Inst_Addr  = pc_q;
  assign ALU_In0    = alu_in0_q;
  assign ALU_In1    = alu_in1_q;
  assign ALU_In2    = alu_in2_q;
  assign Opcode     = opcode_q;
  assign Dm_Wr_En   = wr_en_q;
  assign Dm_Wr_Addr = wr_addr_q;
  assign Dm_Wr_Data = ALU_Out;

endmodule
